// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result bundle
// for serial_adder. The overflow flag exists only when SERIAL_ADDER_OVERFLOW_EN
// is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );
`else
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout
  );
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract unit working DIGIT bits per clock
// through a registered carry. WIDTH-bit operands are captured on an accepted
// start; the result appears N = WIDTH/DIGIT cycles later with a one-cycle done.
// Subtraction is a + ~b + ~cin, so cout=1 means "no borrow".
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN adds the signed overflow flag.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  serial_adder_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // One digit slice: DIGIT-bit add with carry-in, carry-out in the top bit.
  function automatic logic [DIGIT:0] digit_add(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             ci
  );
    digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

`ifdef SERIAL_ADDER_OVERFLOW_EN
  // Carry into the MSB is recovered as xm ^ ym ^ sm; XOR with the MSB carry-out.
  function automatic logic msb_overflow(
    input logic xm,
    input logic ym,
    input logic sm,
    input logic co
  );
    msb_overflow = xm ^ ym ^ sm ^ co;
  endfunction
`endif

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             accept_s;
  logic             last_s;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] psum_r;

  logic [DIGIT:0]   stage_s;
  logic [WIDTH-1:0] psum_nxt_s;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_s;
  logic             ovf_r;
`endif

  assign last_s     = (cnt_r == CNT_LAST);
  assign stage_s    = digit_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
  // The new digit enters from the MSB side; the oldest digit falls off the LSB.
  assign psum_nxt_s = WIDTH'({stage_s[DIGIT-1:0], psum_r} >> DIGIT);

`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign ovf_s = msb_overflow(a_r[DIGIT-1], b_r[DIGIT-1], stage_s[DIGIT-1], stage_s[DIGIT]);
`endif

  // Next-state decode; start is honoured in IDLE and DONE, ignored in RUN.
  always_comb begin
    accept_s    = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s    = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept_s    = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        accept_s    = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register with busy/done registered straight from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand capture on accept, then one digit per cycle through the carry chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      psum_r  <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      a_r     <= bus.a;
      b_r     <= bus.b ^ {WIDTH{bus.sub}};
      carry_r <= bus.sub ? ~bus.cin : bus.cin;
      cnt_r   <= {CW{1'b0}};
      psum_r  <= {WIDTH{1'b0}};
    end else if (state_r == RUN) begin
      a_r     <= a_r >> DIGIT;
      b_r     <= b_r >> DIGIT;
      carry_r <= stage_s[DIGIT];
      cnt_r   <= cnt_r + CNT_ONE;
      psum_r  <= psum_nxt_s;
    end
  end

  // Result registers change only as the last digit completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_r  <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_r  <= 1'b0;
`endif
    end else if ((state_r == RUN) && last_s) begin
      sum_r  <= psum_nxt_s;
      cout_r <= stage_s[DIGIT];
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_r  <= ovf_s;
`endif
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign bus.overflow = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder. Three instances
// (8/1, 8/4 and 1/1 WIDTH/DIGIT) share operands and reset; each has its own
// start. Expected results come from an integer arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] st;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_cin;
  logic       op_sub;

  int checks = 0;
  int errors = 0;

  // 10-unit clock period.
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(8)) if4 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  assign if8.start = st[0];
  assign if8.a     = op_a;
  assign if8.b     = op_b;
  assign if8.cin   = op_cin;
  assign if8.sub   = op_sub;
  assign if4.start = st[1];
  assign if4.a     = op_a;
  assign if4.b     = op_b;
  assign if4.cin   = op_cin;
  assign if4.sub   = op_sub;
  assign if1.start = st[2];
  assign if1.a     = op_a[0];
  assign if1.b     = op_b[0];
  assign if1.cin   = op_cin;
  assign if1.sub   = op_sub;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .reset(rst), .bus(if8));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .reset(rst), .bus(if4));
  serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (.clk(clk), .reset(rst), .bus(if1));

  // Plain arithmetic reference: unsigned result, carry/no-borrow, signed range.
  function automatic void model(input int w, input int a, input int b, input int ci,
                                input int sb, output int s, output int co, output int ov);
    int m, half, sa, sbv, r, sr;
    m    = 1 << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sbv  = (b >= half) ? b - m : b;
    if (sb == 0) begin
      r  = a + b + ci;
      co = (r >= m) ? 1 : 0;
      s  = r % m;
      sr = sa + sbv + ci;
    end else begin
      r  = a - b - ci;
      co = (r >= 0) ? 1 : 0;
      s  = (r + m) % m;
      sr = sa - sbv - ci;
    end
    ov = (sr < -half || sr > half - 1) ? 1 : 0;
  endfunction

  // Read outputs of instance w (0: 8/1, 1: 8/4, 2: 1/1).
  task automatic sample(input int w, output logic dn, output logic bs,
                        output logic [7:0] sm, output logic co, output logic ov);
    ov = 1'b0;
    case (w)
      0: begin
        dn = if8.done; bs = if8.busy; sm = if8.sum; co = if8.cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ov = if8.overflow;
`endif
      end
      1: begin
        dn = if4.done; bs = if4.busy; sm = if4.sum; co = if4.cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ov = if4.overflow;
`endif
      end
      default: begin
        dn = if1.done; bs = if1.busy; sm = {7'd0, if1.sum}; co = if1.cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ov = if1.overflow;
`endif
      end
    endcase
  endtask

  // Issue one operation and wait (bounded) for done; reports latency in cycles
  // after the accepting edge and the number of busy/done protocol violations.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb, output int lat,
                        output logic [7:0] sm, output logic co, output logic ov,
                        output int bad);
    logic dn, bs;
    @(negedge clk);
    op_a = a; op_b = b; op_cin = ci; op_sub = sb;
    st[w] = 1'b1;
    @(posedge clk);
    #1;
    st[w] = 1'b0;
    lat = 0;
    bad = 0;
    sample(w, dn, bs, sm, co, ov);
    if (!bs || dn) bad++;
    while (!dn && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      sample(w, dn, bs, sm, co, ov);
      if (dn && bs) bad++;
      if (!dn && !bs) bad++;
    end
  endtask

  task automatic test_reset();
    logic dn, bs, co, ov;
    logic [7:0] sm;
    for (int w = 0; w < 3; w++) begin
      sample(w, dn, bs, sm, co, ov);
      checks++;
      if ({dn, bs, sm, co, ov} !== 12'h000) begin
        errors++;
        $display("FAIL reset_state dut%0d: done=%b busy=%b sum=%h cout=%b ovf=%b, want all zero",
                 w, dn, bs, sm, co, ov);
      end
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic       tc [4];
    logic       ts [4];
    logic [7:0] es [4];
    logic       ec [4];
    logic       eo [4];
    logic [7:0] sm;
    logic co, ov;
    int lat, bad;
    ta = '{8'h7F, 8'hFF, 8'h05, 8'h80};
    tb = '{8'h01, 8'h01, 8'h07, 8'h01};
    tc = '{1'b0, 1'b1, 1'b0, 1'b0};
    ts = '{1'b0, 1'b0, 1'b1, 1'b1};
    es = '{8'h80, 8'h01, 8'hFE, 8'h7F};
    ec = '{1'b0, 1'b1, 1'b0, 1'b1};
    eo = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        run_op(w, ta[i], tb[i], tc[i], ts[i], lat, sm, co, ov, bad);
        checks++;
        if (lat !== ((w == 0) ? 8 : 2)) begin
          errors++;
          $display("FAIL directed_latency dut%0d case%0d: got %0d, want %0d", w, i, lat, (w == 0) ? 8 : 2);
        end
        checks++;
        if (sm !== es[i] || co !== ec[i]) begin
          errors++;
          $display("FAIL directed_result dut%0d case%0d: got sum=%h cout=%b, want sum=%h cout=%b",
                   w, i, sm, co, es[i], ec[i]);
        end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        checks++;
        if (ov !== eo[i]) begin
          errors++;
          $display("FAIL directed_overflow dut%0d case%0d: got %b, want %b", w, i, ov, eo[i]);
        end
`endif
        checks++;
        if (bad !== 0) begin
          errors++;
          $display("FAIL directed_handshake dut%0d case%0d: got %0d violations, want 0", w, i, bad);
        end
      end
    end
  endtask

  task automatic test_single_bit();
    logic ta [3];
    logic tb [3];
    logic tc [3];
    logic es [3];
    logic ec [3];
    logic [7:0] sm;
    logic co, ov;
    int lat, bad;
    ta = '{1'b0, 1'b0, 1'b1};
    tb = '{1'b0, 1'b1, 1'b1};
    tc = '{1'b0, 1'b0, 1'b1};
    es = '{1'b0, 1'b1, 1'b1};
    ec = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_op(2, {7'd0, ta[i]}, {7'd0, tb[i]}, tc[i], 1'b0, lat, sm, co, ov, bad);
      checks++;
      if (lat !== 1 || bad !== 0) begin
        errors++;
        $display("FAIL single_bit_timing case%0d: got lat=%0d viol=%0d, want lat=1 viol=0", i, lat, bad);
      end
      checks++;
      if (sm[0] !== es[i] || co !== ec[i]) begin
        errors++;
        $display("FAIL single_bit_result case%0d: got sum=%b cout=%b, want sum=%b cout=%b",
                 i, sm[0], co, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic dn, bs, co, ov;
    logic [7:0] sm, first_sm, exp_s;
    logic first_co;
    int s, c, o, ndone, lat;
    model(8, 8'h3C, 8'h5A, 1, 0, s, c, o);
    exp_s = s[7:0];
    ndone = 0;
    lat = -1;
    first_sm = 8'h00;
    first_co = 1'b0;
    @(negedge clk);
    op_a = 8'h3C; op_b = 8'h5A; op_cin = 1'b1; op_sub = 1'b0;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) begin
        op_a = 8'hFF; op_b = 8'hEE; op_cin = 1'b0; op_sub = 1'b1;
        st[0] = 1'b1;
      end else begin
        st[0] = 1'b0;
      end
      @(posedge clk);
      #1;
      sample(0, dn, bs, sm, co, ov);
      if (dn) begin
        ndone++;
        if (lat < 0) begin
          lat = k; first_sm = sm; first_co = co;
        end
      end
    end
    st[0] = 1'b0;
    checks++;
    if (ndone !== 1 || lat !== 8) begin
      errors++;
      $display("FAIL ignore_start_timing: got %0d done pulses first at %0d, want 1 at 8", ndone, lat);
    end
    checks++;
    if (first_sm !== exp_s || first_co !== c[0]) begin
      errors++;
      $display("FAIL ignore_start_result: got sum=%h cout=%b, want sum=%h cout=%b",
               first_sm, first_co, exp_s, c[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic dn, bs, co, ov;
    logic [7:0] sm, a1, b1, a2, b2, r1, r2, e1, e2;
    logic c1, c2;
    int s, c, o, s2, cc2, o2, first, second, ndone;
    a1 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    a2 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    model(8, int'(a1), int'(b1), 0, 0, s, c, o);
    model(8, int'(a2), int'(b2), 1, 1, s2, cc2, o2);
    e1 = s[7:0];
    e2 = s2[7:0];
    first = -1; second = -1; ndone = 0;
    r1 = 8'h00; r2 = 8'h00; c1 = 1'b0; c2 = 1'b0;
    @(negedge clk);
    op_a = a1; op_b = b1; op_cin = 1'b0; op_sub = 1'b0;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    op_a = a2; op_b = b2; op_cin = 1'b1; op_sub = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      sample(0, dn, bs, sm, co, ov);
      if (first >= 0 && k == first + 1) begin
        st[0] = 1'b0;
        checks++;
        if (bs !== 1'b1 || dn !== 1'b0) begin
          errors++;
          $display("FAIL b2b_restart: got busy=%b done=%b after done cycle, want busy=1 done=0", bs, dn);
        end
      end
      if (dn) begin
        ndone++;
        if (first < 0) begin
          first = k; r1 = sm; c1 = co;
        end else if (second < 0) begin
          second = k; r2 = sm; c2 = co;
        end
      end
    end
    st[0] = 1'b0;
    checks++;
    if (first !== 8 || second - first !== 9 || ndone !== 2) begin
      errors++;
      $display("FAIL b2b_timing: got done at %0d and %0d (%0d pulses), want 8 and 17 (2 pulses)",
               first, second, ndone);
    end
    checks++;
    if (r1 !== e1 || c1 !== c[0] || r2 !== e2 || c2 !== cc2[0]) begin
      errors++;
      $display("FAIL b2b_result: got %h/%b then %h/%b, want %h/%b then %h/%b",
               r1, c1, r2, c2, e1, c[0], e2, cc2[0]);
    end
  endtask

  task automatic test_async_reset();
    logic dn, bs, co, ov;
    logic [7:0] sm, exp_s;
    int lat, bad, s, c, o;
    run_op(0, 8'hA5, 8'h3C, 1'b0, 1'b0, lat, sm, co, ov, bad);
    checks++;
    if (sm !== 8'hE1) begin
      errors++;
      $display("FAIL pre_reset_result: got sum=%h, want e1", sm);
    end
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; op_cin = 1'b0; op_sub = 1'b0;
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    sample(0, dn, bs, sm, co, ov);
    checks++;
    if ({dn, bs, sm, co, ov} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got done=%b busy=%b sum=%h cout=%b ovf=%b, want all zero",
               dn, bs, sm, co, ov);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 8'h9C, 8'h27, 1'b1, 1'b1, lat, sm, co, ov, bad);
    model(8, 8'h9C, 8'h27, 1, 1, s, c, o);
    exp_s = s[7:0];
    checks++;
    if (lat !== 8 || bad !== 0 || sm !== exp_s || co !== c[0]) begin
      errors++;
      $display("FAIL post_reset_op: got lat=%0d viol=%0d sum=%h cout=%b, want lat=8 viol=0 sum=%h cout=%b",
               lat, bad, sm, co, exp_s, c[0]);
    end
  endtask

  task automatic test_random(input int w, input int nops);
    logic [7:0] a, b, sm, exp_s;
    logic ci, sb, co, ov;
    int lat, bad, s, c, o, bits, want_lat;
    bits     = (w == 2) ? 1 : 8;
    want_lat = (w == 0) ? 8 : ((w == 1) ? 2 : 1);
    for (int i = 0; i < nops; i++) begin
      a  = 8'($urandom_range(0, (1 << bits) - 1));
      b  = 8'($urandom_range(0, (1 << bits) - 1));
      ci = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      run_op(w, a, b, ci, sb, lat, sm, co, ov, bad);
      model(bits, int'(a), int'(b), int'(ci), int'(sb), s, c, o);
      exp_s = s[7:0];
      checks++;
      if (lat !== want_lat || bad !== 0) begin
        errors++;
        $display("FAIL random_timing dut%0d op%0d: got lat=%0d viol=%0d, want lat=%0d viol=0",
                 w, i, lat, bad, want_lat);
      end
      checks++;
      if (sm !== exp_s || co !== c[0]) begin
        errors++;
        $display("FAIL random_result dut%0d op%0d a=%h b=%h cin=%b sub=%b: got %h/%b, want %h/%b",
                 w, i, a, b, ci, sb, sm, co, exp_s, c[0]);
      end
`ifdef SERIAL_ADDER_OVERFLOW_EN
      checks++;
      if (ov !== o[0]) begin
        errors++;
        $display("FAIL random_overflow dut%0d op%0d: got %b, want %b", w, i, ov, o[0]);
      end
`endif
    end
  endtask

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Test sequence.
  initial begin
    rst = 1'b1;
    st = 3'b000;
    op_a = 8'h00; op_b = 8'h00; op_cin = 1'b0; op_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_single_bit();
    test_ignore_start();
    repeat (2) @(posedge clk);
    test_back_to_back();
    repeat (2) @(posedge clk);
    test_async_reset();
    test_random(1, 1000);
    test_random(0, 100);
    test_random(2, 100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
